// File: rtl/count_capture_fifo_if.sv
// Capture/drain bus for count_capture_fifo: sample inputs, read strobe and FIFO status.
interface count_capture_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MCNT_W = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] count_in;
    logic              count_valid;
    logic              capture;
    logic              rd_en;
    logic [DATA_W-1:0] match_val;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              match;
    logic [MCNT_W-1:0] match_cnt;

    modport master (
        output count_in, count_valid, capture, rd_en, match_val,
        input  dout, dout_valid, full, empty, level, overflow, match, match_cnt
    );

    modport slave (
        input  count_in, count_valid, capture, rd_en, match_val,
        output dout, dout_valid, full, empty, level, overflow, match, match_cnt
    );
endinterface

// File: rtl/count_capture_fifo.sv
// Snapshots the event counter on capture rising edges into a FWFT FIFO,
// with sticky overflow and a saturating tally of captures equal to match_val.
module count_capture_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MCNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    count_capture_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [MCNT_W-1:0] MCNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              capture_d;
    logic              overflow_q;
    logic              match_q;
    logic [MCNT_W-1:0] match_cnt_q;

    logic cap_edge_c;
    logic empty_c;
    logic full_c;
    logic pop_ok_c;
    logic push_ok_c;
    logic hit_c;

    // Request qualification; a full FIFO still takes a push when the head leaves in the same cycle
    always_comb begin
        cap_edge_c = 1'b0;
        empty_c    = 1'b0;
        full_c     = 1'b0;
        pop_ok_c   = 1'b0;
        push_ok_c  = 1'b0;
        hit_c      = 1'b0;

        cap_edge_c = bus.capture & ~capture_d & bus.count_valid;
        empty_c    = (level_q == '0);
        full_c     = (level_q == LVL_W'(DEPTH));
        pop_ok_c   = bus.rd_en & ~empty_c;
        push_ok_c  = cap_edge_c & (~full_c | pop_ok_c);
        hit_c      = (bus.count_in == bus.match_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            capture_d   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            match_q     <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            capture_d <= bus.capture;
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c);
            if (cap_edge_c && !push_ok_c) begin
                overflow_q <= 1'b1;
            end
            match_q <= push_ok_c & hit_c;
            if (push_ok_c && hit_c && (match_cnt_q != MCNT_MAX)) begin
                match_cnt_q <= match_cnt_q + MCNT_W'(1);
            end
        end
    end

    // Storage carries no reset; pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push_ok_c && !reset) begin
            mem[wr_ptr] <= bus.count_in;
        end
    end

    assign bus.dout       = empty_c ? '0 : mem[rd_ptr];
    assign bus.dout_valid = ~empty_c;
    assign bus.empty      = empty_c;
    assign bus.full       = full_c;
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.match      = match_q;
    assign bus.match_cnt  = match_cnt_q;
endmodule

// File: tb/tb_count_capture_fifo.sv
// Scoreboard bench for count_capture_fifo: directed captures queue expected samples,
// a negedge monitor pops and compares whenever the host reads a valid head.
module tb_count_capture_fifo;
    logic clk;
    logic reset;

    int checks;
    int errors;
    int mlevel;
    int match_seen;
    int base_seen;
    logic pcap;
    logic [7:0] exp_q [$];

    count_capture_fifo_if #(.DATA_W(8), .DEPTH(4), .MCNT_W(4)) bus ();

    count_capture_fifo #(.DATA_W(8), .DEPTH(4), .MCNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model follows the specified push/pop rules
    task automatic cyc(input logic cap, input logic [7:0] v, input logic vld, input logic rd);
        logic edge_s;
        logic pop_s;
        logic acc_s;
        bus.capture     = cap;
        bus.count_in    = v;
        bus.count_valid = vld;
        bus.rd_en       = rd;
        @(posedge clk);
        edge_s = cap && !pcap && vld;
        pop_s  = rd && (mlevel != 0);
        acc_s  = edge_s && ((mlevel < 4) || pop_s);
        if (acc_s) exp_q.push_back(v);
        mlevel = mlevel + int'(acc_s) - int'(pop_s);
        pcap = cap;
        #1;
    endtask

    task automatic rst(input int n);
        reset       = 1'b1;
        bus.capture = 1'b0;
        bus.rd_en   = 1'b0;
        repeat (n) @(posedge clk);
        exp_q.delete();
        mlevel = 0;
        pcap   = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    // Monitor: tracks occupancy and compares the head on every accepted read
    always @(negedge clk) begin
        if (!reset) begin
            chk("level_track", 32'(bus.level), 32'(mlevel));
            chk("valid_track", 32'(bus.dout_valid), 32'(mlevel != 0));
            if (bus.match) match_seen++;
            if (bus.rd_en && bus.dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_data: got %0h expected nothing queued", bus.dout);
                end else begin
                    chk("pop_data", 32'(bus.dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        mlevel = 0;
        match_seen = 0;
        pcap = 1'b0;
        bus.count_in    = 8'h00;
        bus.count_valid = 1'b0;
        bus.capture     = 1'b0;
        bus.rd_en       = 1'b0;
        bus.match_val   = 8'h10;

        // Reset then idle
        rst(2);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_match_cnt", 32'(bus.match_cnt), 0);

        // Single capture, strobe held high for 5 cycles
        cyc(1'b1, 8'h1F, 1'b1, 1'b0);
        chk("single_level", 32'(bus.level), 1);
        chk("single_dout", 32'(bus.dout), 32'h1F);
        repeat (4) cyc(1'b1, 8'h1F, 1'b1, 1'b0);
        chk("held_level", 32'(bus.level), 1);
        idle();
        pop();
        chk("single_drained", 32'(bus.empty), 1);

        // Fill and overflow
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(3 + i), 1'b1, 1'b0);
            if (i == 3) begin
                chk("fill_full", 32'(bus.full), 1);
                chk("fill_no_ovf", 32'(bus.overflow), 0);
            end
            idle();
        end
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_level", 32'(bus.level), 4);
        repeat (4) pop();
        chk("ovf_drained", 32'(bus.empty), 1);
        chk("ovf_sticky", 32'(bus.overflow), 1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h21 + i), 1'b1, 1'b0);
            idle();
        end
        cyc(1'b1, 8'h09, 1'b1, 1'b1);
        chk("full_pp_level", 32'(bus.level), 4);
        idle();
        repeat (3) pop();
        chk("full_pp_last", 32'(bus.dout), 32'h09);
        pop();
        chk("full_pp_drained", 32'(bus.empty), 1);

        // Simultaneous push and pop while empty
        cyc(1'b1, 8'h02, 1'b1, 1'b1);
        chk("empty_pp_level", 32'(bus.level), 1);
        chk("empty_pp_dout", 32'(bus.dout), 32'h02);
        idle();
        pop();

        // Gating: an edge without count_valid is lost, not retried
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("gate_level", 32'(bus.level), 0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("gate_no_retry", 32'(bus.level), 0);
        idle();

        // Match pulses and tally
        base_seen = match_seen;
        cyc(1'b1, 8'h10, 1'b1, 1'b0);
        chk("match1_pulse", 32'(bus.match), 1);
        chk("match1_cnt", 32'(bus.match_cnt), 1);
        idle();
        chk("match1_end", 32'(bus.match), 0);
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        chk("nomatch_pulse", 32'(bus.match), 0);
        idle();
        cyc(1'b1, 8'h10, 1'b1, 1'b0);
        chk("match2_pulse", 32'(bus.match), 1);
        idle();
        chk("match2_end", 32'(bus.match), 0);
        chk("match_cnt2", 32'(bus.match_cnt), 2);
        chk("match_pulses", 32'(match_seen - base_seen), 2);
        repeat (3) pop();

        // Tally saturates at 15
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'h10, 1'b1, 1'b0);
            pop();
        end
        chk("match_sat", 32'(bus.match_cnt), 15);

        // Dropped sample never matches; then reset mid-operation
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h31 + i), 1'b1, 1'b0);
            idle();
        end
        cyc(1'b1, 8'h10, 1'b1, 1'b0);
        chk("drop_no_match", 32'(bus.match), 0);
        idle();
        pop();
        chk("mid_level", 32'(bus.level), 3);
        chk("mid_overflow", 32'(bus.overflow), 1);
        rst(1);
        chk("mid_rst_level", 32'(bus.level), 0);
        chk("mid_rst_overflow", 32'(bus.overflow), 0);
        chk("mid_rst_dout", 32'(bus.dout), 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_match_cnt", 32'(bus.match_cnt), 0);
        cyc(1'b1, 8'h44, 1'b1, 1'b0);
        chk("post_rst_level", 32'(bus.level), 1);
        chk("post_rst_dout", 32'(bus.dout), 32'h44);
        idle();
        pop();
        chk("post_rst_empty", 32'(bus.empty), 1);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
